// File: rtl/fetch_buffer_pkg.sv
// Shared defaults for the fetch stage: address/instruction widths, FIFO depth,
// the PC reset address, and the {addr, instr} entry layout width.
package fetch_buffer_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int INSTR_W_DEF = 15;
    localparam int DEPTH_DEF   = 2;

    localparam logic [ADDR_W_DEF-1:0] PC_RESET = '0;

    // A FIFO entry is {addr, instr}, with the address in the upper bits.
    function automatic int entry_w(input int addr_w, input int instr_w);
        return addr_w + instr_w;
    endfunction

endpackage

// File: rtl/fetch_buffer_fifo.sv
// DEPTH-entry synchronous FIFO with flush. A push and a pop in the same cycle
// are accepted even when the FIFO is full.
module fetch_buffer_fifo #(
    parameter int WIDTH = 23,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    assign w_do_pop  = i_pop & (r_count != '0);
    assign w_do_push = i_push & ((r_count != CNT_W'(DEPTH)) | w_do_pop);

    // Storage is cleared on reset so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch stage: pairs each ROM word with the address fetched one
// cycle earlier, buffers it, and replays the PC when the buffer overflows.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_addr,
    output logic               rom_en,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               jump,
    input  logic [ADDR_W-1:0]  jump_addr,
    output logic               pc_load,
    output logic [ADDR_W-1:0]  pc_new_addr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_addr
);

    localparam int ENTRY_W = entry_w(ADDR_W, INSTR_W);
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0]  r_inflight_addr_p1;
    logic               r_inflight_v_p1;
    logic               r_squash;

    logic               w_pop;
    logic               w_space;
    logic               w_arrival;
    logic               w_push;
    logic               w_drop;
    logic               w_full;
    logic               w_empty;
    logic [CNT_W-1:0]   w_count;
    logic [ENTRY_W-1:0] w_head;

    assign rom_en   = reset;
    assign rom_addr = pc_addr;

    assign w_pop     = out_valid & out_ready;
    assign w_space   = (w_count < CNT_W'(DEPTH)) | w_pop;
    assign w_arrival = r_inflight_v_p1 & ~r_squash & ~jump;
    assign w_push    = w_arrival & w_space;
    assign w_drop    = w_arrival & w_full & ~w_pop;

    // A jump outranks a replay; the PC never sees a load while held in reset.
    assign pc_load     = reset & (jump | w_drop);
    assign pc_new_addr = jump ? jump_addr : r_inflight_addr_p1;

    // Stage p0 -> p1: the address fetched this cycle meets its ROM word next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_inflight_addr_p1 <= ADDR_W'(PC_RESET);
            r_inflight_v_p1    <= 1'b0;
            r_squash           <= 1'b0;
        end else begin
            r_inflight_addr_p1 <= pc_addr;
            r_inflight_v_p1    <= 1'b1;
            r_squash           <= jump | w_drop;
        end
    end

    fetch_buffer_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (jump),
        .i_data  ({r_inflight_addr_p1, rom_data}),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign out_valid = ~w_empty;
    assign out_addr  = w_head[ENTRY_W-1:INSTR_W];
    assign out_instr = w_head[INSTR_W-1:0];

endmodule
